rd_lat_meas: RTL and testbench

- Read-latency measurement stage of the memory checker, in the memory clock domain.
- Snoops the Avalon-MM read port between the test engine and memory, timestamps each accepted read, and matches it to its readdatavalid in order.
- Accumulates min/max/sum latency and accepted-read count.
- Drives the min_max, sum and rd_req result registers that the CSR block exposes to software.

---
 rtl/mem_checker_pkg.sv | 36 +++
 rtl/ts_fifo.sv | 69 ++++++
 rtl/rd_lat_meas.sv | 183 ++++++++++++++++++
 tb/tb_rd_lat_meas.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_checker_pkg.sv
// Shared types and constants for the memory checker measurement stages.
// Defining RD_TIMEOUT_EN widens the error vector with a read-timeout flag.
package mem_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } meas_state_e;

    localparam int STAT_TS_W  = 16;
    localparam int STAT_SUM_W = 32;
    localparam int STAT_REQ_W = 32;

    typedef struct packed {
        logic [STAT_TS_W-1:0]  min;
        logic [STAT_TS_W-1:0]  max;
        logic [STAT_SUM_W-1:0] sum;
        logic [STAT_REQ_W-1:0] rd_req;
    } lat_stat_t;

    localparam int ERR_OVF     = 0;
    localparam int ERR_ORPHAN  = 1;
    localparam int ERR_TIMEOUT = 2;
`ifdef RD_TIMEOUT_EN
    localparam int ERR_W = 3;
`else
    localparam int ERR_W = 2;
`endif

    localparam int MM_W    = 32;
    localparam int MIN_LSB = 0;
    localparam int MAX_LSB = 16;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous FIFO holding read-accept timestamps; push and pop may coincide,
// and a flush empties it while still honouring a push in the same cycle.
module ts_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    wr_addr;
    logic             do_push, do_pop;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned (no latch).
    always_comb begin
        do_pop   = pop_i & ~empty_o & ~flush_i;
        do_push  = push_i & (flush_i | ~full_o | do_pop);
        wr_ptr_d = flush_i ? '0 : wr_ptr_q;
        rd_ptr_d = flush_i ? '0 : rd_ptr_q;
        count_d  = flush_i ? '0 : count_q;
        wr_addr  = wr_ptr_d;
        if (do_push) begin
            wr_ptr_d = wr_ptr_d + AW'(1);
            count_d  = count_d + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_d + AW'(1);
            count_d  = count_d - (AW+1)'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_addr] <= din_i;
        end
    end

endmodule

// File: rtl/rd_lat_meas.sv
// Read-latency measurement: timestamps accepted Avalon reads, matches them in
// order to readdatavalid and accumulates min/max/sum/count. Optional RD_TIMEOUT_EN.
module rd_lat_meas
    import mem_checker_pkg::*;
#(
    parameter int TS_W     = 16,
    parameter int MAX_PEND = 8,
    parameter int SUM_W    = 32,
    parameter int REQ_W    = 32
) (
    input  logic             clk_mem_i,
    input  logic             rst_mem_i,
    input  logic             meas_start_i,
    input  logic             meas_stop_i,
    input  logic             mem_read_i,
    input  logic             mem_waitrequest_i,
    input  logic             mem_readdatavalid_i,
    output logic [MM_W-1:0]  min_max_o,
    output logic [SUM_W-1:0] sum_o,
    output logic [REQ_W-1:0] rd_req_o,
    output logic             meas_busy_o,
    output logic             meas_done_o,
    output logic [ERR_W-1:0] meas_err_o
);

    meas_state_e      state_q, state_d;
    logic [TS_W-1:0]  ts_q;
    logic [TS_W-1:0]  head_ts;
    logic             fifo_full, fifo_empty;
    logic             accept, active, push, pop, orphan, ovf, flush, drain_abort;

    logic [TS_W-1:0]  lat_q, lat_d;
    logic             lat_vld_q, lat_vld_d;
    logic [TS_W-1:0]  min_q, min_d, max_q, max_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [SUM_W:0]   sum_ext;
    logic [REQ_W-1:0] rd_req_q, rd_req_d;
    logic             have_lat_q, have_lat_d;
    logic [ERR_W-1:0] err_q, err_d;

    assign accept = mem_read_i & ~mem_waitrequest_i;
    assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // A start flushes the FIFO yet still captures a read accepted in that same cycle.
    assign pop    = mem_readdatavalid_i & active & ~meas_start_i & ~fifo_empty;
    assign orphan = mem_readdatavalid_i & active & ~meas_start_i & fifo_empty;
    assign push   = accept & (meas_start_i | ((state_q == ST_RUN) & (~fifo_full | pop)));
    assign ovf    = accept & (state_q == ST_RUN) & ~meas_start_i & fifo_full & ~pop;
    assign flush  = meas_start_i | drain_abort;

    ts_fifo #(
        .WIDTH (TS_W),
        .DEPTH (MAX_PEND)
    ) u_ts_fifo (
        .clk_i   (clk_mem_i),
        .rst_i   (rst_mem_i),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ts_q),
        .dout_o  (head_ts),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef RD_TIMEOUT_EN
    logic [TS_W-1:0] age_q, age_d;
    logic            timeout;

    assign timeout     = active & ~fifo_empty & (&age_q);
    assign drain_abort = timeout & (state_q == ST_DRAIN);

    always_comb begin
        age_d = age_q;
        if (flush || pop || fifo_empty) begin
            age_d = '0;
        end else if (!(&age_q)) begin
            age_d = age_q + TS_W'(1);
        end
    end

    always_ff @(posedge clk_mem_i) begin
        if (rst_mem_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign drain_abort = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (meas_start_i) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (meas_stop_i) state_d = ST_DRAIN;
                // The last latency in stage 1 commits on the same edge that enters DONE.
                ST_DRAIN: if (fifo_empty || drain_abort) state_d = ST_DONE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        lat_d      = ts_q - head_ts;
        lat_vld_d  = pop;
        min_d      = min_q;
        max_d      = max_q;
        sum_d      = sum_q;
        rd_req_d   = rd_req_q;
        have_lat_d = have_lat_q;
        err_d      = err_q;
        sum_ext    = {1'b0, sum_q} + (SUM_W+1)'(lat_q);
        if (meas_start_i) begin
            min_d      = '1;
            max_d      = '0;
            sum_d      = '0;
            rd_req_d   = REQ_W'(accept);
            have_lat_d = 1'b0;
            err_d      = '0;
        end else begin
            if (lat_vld_q) begin
                if (lat_q < min_q) min_d = lat_q;
                if (lat_q > max_q) max_d = lat_q;
                sum_d      = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
                have_lat_d = 1'b1;
            end
            if (accept && (state_q == ST_RUN) && !(&rd_req_q)) begin
                rd_req_d = rd_req_q + REQ_W'(1);
            end
            if (ovf)    err_d[ERR_OVF]    = 1'b1;
            if (orphan) err_d[ERR_ORPHAN] = 1'b1;
`ifdef RD_TIMEOUT_EN
            if (timeout) err_d[ERR_TIMEOUT] = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_mem_i) begin
        if (rst_mem_i) begin
            state_q    <= ST_IDLE;
            ts_q       <= '0;
            lat_q      <= '0;
            lat_vld_q  <= 1'b0;
            min_q      <= '1;
            max_q      <= '0;
            sum_q      <= '0;
            rd_req_q   <= '0;
            have_lat_q <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            ts_q       <= ts_q + TS_W'(1);
            lat_q      <= lat_d;
            lat_vld_q  <= lat_vld_d;
            min_q      <= min_d;
            max_q      <= max_d;
            sum_q      <= sum_d;
            rd_req_q   <= rd_req_d;
            have_lat_q <= have_lat_d;
            err_q      <= err_d;
        end
    end

    // The internal all-ones minimum stays hidden until a latency has landed.
    always_comb begin
        min_max_o                    = '0;
        min_max_o[MAX_LSB +: TS_W]   = max_q;
        if (have_lat_q) begin
            min_max_o[MIN_LSB +: TS_W] = min_q;
        end
    end

    assign sum_o       = sum_q;
    assign rd_req_o    = rd_req_q;
    assign meas_busy_o = active;
    assign meas_done_o = (state_q == ST_DONE);
    assign meas_err_o  = err_q;

endmodule

// File: tb/tb_rd_lat_meas.sv
// Scoreboard bench for rd_lat_meas: directed patterns push expected results,
// a negedge monitor compares on probes and on each rising meas_done_o.
module tb_rd_lat_meas;
    import mem_checker_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             meas_start, meas_stop, mem_read, mem_wait, mem_rvalid;
    logic [MM_W-1:0]  min_max;
    logic [31:0]      sum, rd_req;
    logic             busy, done;
    logic [ERR_W-1:0] err;

    rd_lat_meas dut (
        .clk_mem_i           (clk),
        .rst_mem_i           (rst),
        .meas_start_i        (meas_start),
        .meas_stop_i         (meas_stop),
        .mem_read_i          (mem_read),
        .mem_waitrequest_i   (mem_wait),
        .mem_readdatavalid_i (mem_rvalid),
        .min_max_o           (min_max),
        .sum_o               (sum),
        .rd_req_o            (rd_req),
        .meas_busy_o         (busy),
        .meas_done_o         (done),
        .meas_err_o          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          tid;
        logic [31:0] mm;
        logic [31:0] sum;
        logic [31:0] rdq;
        logic [2:0]  err;
        logic        busy;
        logic        done;
        int          done_cyc;
    } exp_t;

    exp_t probe_q[$];
    exp_t done_q[$];
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   probe_cnt  = 0;
    int   probe_seen = 0;

    task automatic check(input string name, input int tid, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL t%0d %s: got 0x%0h expected 0x%0h", tid, name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int tid, input logic [31:0] mm, input logic [31:0] s,
                                input logic [31:0] rq, input logic [2:0] e,
                                input logic b, input logic d);
        exp_t x;
        x.tid = tid; x.mm = mm; x.sum = s; x.rdq = rq; x.err = e;
        x.busy = b; x.done = d; x.done_cyc = -1;
        return x;
    endfunction

    function automatic logic [39:0] b(input int lo, input int hi);
        logic [39:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic compare(input exp_t e);
        check("min_max", e.tid, min_max, e.mm);
        check("sum", e.tid, sum, e.sum);
        check("rd_req", e.tid, rd_req, e.rdq);
        check("err", e.tid, 32'(err), 32'(e.err));
        check("busy", e.tid, 32'(busy), 32'(e.busy));
        check("done", e.tid, 32'(done), 32'(e.done));
        if (e.done_cyc >= 0) check("done_cycle", e.tid, cyc, e.done_cyc);
    endtask

    // Monitor: decoupled from stimulus, compares only when the DUT presents a result.
    initial begin
        logic done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (probe_cnt != probe_seen) begin
                    probe_seen = probe_cnt;
                    if (probe_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL probe: got probe with no expected entry");
                    end else begin
                        compare(probe_q.pop_front());
                    end
                end
                if (done && !done_prev) begin
                    if (done_q.size() == 0) begin
                        n_checks++; n_errors++;
                        $display("FAIL done_rise: got unexpected done at cycle %0d expected none", cyc);
                    end else begin
                        compare(done_q.pop_front());
                    end
                end
                done_prev = done;
            end
        end
    end

    task automatic run_pat(input int len, input logic [39:0] st, input logic [39:0] sp,
                           input logic [39:0] rd, input logic [39:0] wr, input logic [39:0] rv,
                           input logic [39:0] pr, input exp_t ep, input int done_off, input exp_t ed);
        exp_t d = ed;
        if (done_off >= 0) begin
            d.done_cyc = cyc + done_off;
            done_q.push_back(d);
        end
        for (int i = 0; i < len; i++) begin
            meas_start = st[i];
            meas_stop  = sp[i];
            mem_read   = rd[i];
            mem_wait   = wr[i];
            mem_rvalid = rv[i];
            if (pr[i]) begin
                probe_q.push_back(ep);
                probe_cnt++;
            end
            @(posedge clk);
            #1;
        end
        meas_start = 1'b0; meas_stop = 1'b0; mem_read = 1'b0; mem_wait = 1'b0; mem_rvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t none;
        none = mk(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        meas_start = 1'b0; meas_stop = 1'b0; mem_read = 1'b0; mem_wait = 1'b0; mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        run_pat(2, 0, 0, 0, 0, 0, b(0, 0), mk(0, 0, 0, 0, 0, 0, 0), -1, none);

        // Single read, latency 5
        run_pat(11, b(0, 0), b(7, 7), b(1, 1), 0, b(6, 6), 0, none,
                9, mk(1, 32'h0005_0005, 5, 1, 0, 0, 1));

        // Four reads, latencies 3,7,4,10 (cycle 9 pushes and pops together)
        run_pat(25, b(0, 0), b(21, 21), b(1, 2) | b(9, 10), 0,
                b(4, 4) | b(9, 9) | b(13, 13) | b(20, 20), 0, none,
                23, mk(2, 32'h000A_0003, 24, 4, 0, 0, 1));

        // Read and rvalid while DONE are ignored; waitrequest held 3 cycles; latency 2 from accept
        run_pat(12, b(1, 1), b(8, 8), b(0, 0) | b(2, 5), b(2, 4), b(0, 0) | b(7, 7), 0, none,
                10, mk(3, 32'h0002_0002, 2, 1, 0, 0, 1));

        // Nine outstanding reads overflow an 8-deep FIFO; ninth rvalid is an orphan
        run_pat(34, b(0, 0), b(30, 30), b(1, 9), 0, b(21, 29), b(11, 11),
                mk(4, 0, 0, 9, 3'b001, 1, 0),
                32, mk(4, 32'h0014_0014, 160, 9, 3'b011, 0, 1));

        // Stop with two outstanding; read in DRAIN not counted; done 2 cycles after last rvalid
        run_pat(14, b(0, 0), b(3, 3), b(1, 2) | b(4, 4), 0, b(7, 7) | b(10, 10), 0, none,
                12, mk(5, 32'h0008_0006, 14, 2, 0, 0, 1));

        // Restart mid-RUN with three outstanding; later rvalids are orphans
        run_pat(18, b(0, 0) | b(9, 9), b(14, 14), b(1, 1) | b(5, 7), 0,
                b(4, 4) | b(11, 13), b(10, 10), mk(6, 0, 0, 0, 0, 1, 0),
                16, mk(6, 0, 0, 0, 3'b010, 0, 1));

        // Start, stop and a read in one cycle: start wins and the read is counted
        run_pat(9, b(0, 0), b(0, 0) | b(5, 5), b(0, 0), 0, b(4, 4), 0, none,
                7, mk(7, 32'h0004_0004, 4, 1, 0, 0, 1));

        for (int i = 0; i < 50 && (probe_q.size() + done_q.size()) != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("queues_drained", 99, 32'(probe_q.size() + done_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
